// File: rtl/ddr_word_tx_ctrl_if.sv
// Bundle between the HDR-DDR engine, the SCL-edge bit counter and the SDA mux
// for the single-word transmitter.
interface ddr_word_tx_ctrl_if #(
   parameter int CNT_W = 5
);
   logic             i_start;
   logic [15:0]      i_word;
   logic [1:0]       i_preamble;
   logic             i_abort;
   logic [CNT_W-1:0] i_bit_count;
   logic             o_bitcnt_en;
   logic             o_sda_out;
   logic             o_busy;
   logic             o_done;
   logic [1:0]       o_phase;

   modport master (
      output i_start, i_word, i_preamble, i_abort, i_bit_count,
      input  o_bitcnt_en, o_sda_out, o_busy, o_done, o_phase
   );

   modport slave (
      input  i_start, i_word, i_preamble, i_abort, i_bit_count,
      output o_bitcnt_en, o_sda_out, o_busy, o_done, o_phase
   );
endinterface

// File: rtl/ddr_word_tx_ctrl.sv
// Sequences one HDR-DDR word (2 preamble, 16 data, 2 parity bits) onto SDA,
// indexing the frame by the external SCL-edge bit count it enables.
module ddr_word_tx_ctrl #(
   parameter int CNT_W     = 5,
   parameter int FRAME_LEN = 20
) (
   input logic               i_sys_clk,
   input logic               i_rst_n,
   ddr_word_tx_ctrl_if.slave bus
);
   localparam int FRAME_W = 20;
   localparam logic [CNT_W-1:0] CNT_END        = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_DATA_START = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_PAR_START  = CNT_W'(18);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t               state_q;
   logic [FRAME_W-1:0]   frame_q;
   logic [FRAME_W-1:0]   frame_d;
   logic [FRAME_W-1:0]   frame_shifted;
   logic                 bitcnt_en_q;
   logic                 done_q;
   logic                 pa1;
   logic                 pa0;
   logic                 sda;
   logic [1:0]           phase;

   // PA1 covers the odd data bits, PA0 the even ones with an inverted sense.
   assign pa1     = ^(bus.i_word & 16'hAAAA);
   assign pa0     = ~(^(bus.i_word & 16'h5555));
   assign frame_d = {bus.i_preamble, bus.i_word, pa1, pa0};

   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= IDLE;
         frame_q     <= '0;
         bitcnt_en_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.i_start && !bus.i_abort) begin
                  frame_q     <= frame_d;
                  bitcnt_en_q <= 1'b1;
                  state_q     <= RUN;
               end
            end
            RUN: begin
               // Abort outranks completion; an overshooting count also ends the word.
               if (bus.i_abort) begin
                  bitcnt_en_q <= 1'b0;
                  state_q     <= IDLE;
               end else if (bus.i_bit_count >= CNT_END) begin
                  bitcnt_en_q <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               bitcnt_en_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               bitcnt_en_q <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign frame_shifted = frame_q << bus.i_bit_count;

   // SDA and phase track the live bit count with no register in between.
   always_comb begin
      sda   = 1'b1;
      phase = 2'd3;
      if (state_q == RUN) begin
         if (bus.i_bit_count < CNT_END) begin
            sda = frame_shifted[FRAME_W-1];
         end
         if (bus.i_bit_count < CNT_DATA_START) begin
            phase = 2'd0;
         end else if (bus.i_bit_count < CNT_PAR_START) begin
            phase = 2'd1;
         end else begin
            phase = 2'd2;
         end
      end
   end

   assign bus.o_bitcnt_en = bitcnt_en_q;
   assign bus.o_done      = done_q;
   assign bus.o_busy      = (state_q != IDLE);
   assign bus.o_sda_out   = sda;
   assign bus.o_phase     = phase;
endmodule

// File: tb/tb_ddr_word_tx_ctrl.sv
// Randomized and directed bench for ddr_word_tx_ctrl with a word-level
// reference model and a behavioural SCL bit counter.
module tb_ddr_word_tx_ctrl;
   localparam int FRAME_LEN = 20;

   logic clk = 1'b0;
   logic rstN = 1'b0;

   ddr_word_tx_ctrl_if #(.CNT_W(5)) busIf ();

   ddr_word_tx_ctrl #(.CNT_W(5), .FRAME_LEN(FRAME_LEN)) dut (
      .i_sys_clk (clk),
      .i_rst_n   (rstN),
      .bus       (busIf)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: a word is either being sent, in its finishing cycle, or absent.
   bit          mActive = 1'b0;
   bit          mFinish = 1'b0;
   logic [0:19] mFrame  = '0;
   int          mDones  = 0;

   logic [4:0]  cnt = '0;
   int          jumpTo = -1;
   logic        sampledEn = 1'b0;
   logic        lastBusy = 1'b0;
   logic        lastDone = 1'b0;
   int          dutDones = 0;
   logic [0:19] cap = '0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [0:19] buildFrame(input logic [1:0] pre, input logic [15:0] w);
      logic [0:19] f;
      f[0] = pre[1];
      f[1] = pre[0];
      for (int b = 0; b < 16; b++) f[2+b] = w[15-b];
      f[18] = ($countones(w & 16'hAAAA) % 2) == 1;
      f[19] = ($countones(w & 16'h5555) % 2) == 0;
      return f;
   endfunction

   function automatic logic [1:0] expPhase(input logic [4:0] c);
      if (c < 2) return 2'd0;
      if (c < 18) return 2'd1;
      return 2'd2;
   endfunction

   // One clock: drive inputs, check at the falling edge, advance model and counter at the rising edge.
   task automatic applyStimulus(input bit st, input bit ab, input logic [15:0] w, input logic [1:0] p);
      busIf.i_start    = st;
      busIf.i_abort    = ab;
      busIf.i_word     = w;
      busIf.i_preamble = p;
      @(negedge clk);
      checkOutput("bitcntEn", {31'd0, busIf.o_bitcnt_en}, {31'd0, mActive});
      checkOutput("busy", {31'd0, busIf.o_busy}, {31'd0, (mActive || mFinish)});
      checkOutput("done", {31'd0, busIf.o_done}, {31'd0, mFinish});
      if (!mActive) begin
         checkOutput("sdaIdle", {31'd0, busIf.o_sda_out}, 32'd1);
         checkOutput("phaseIdle", {30'd0, busIf.o_phase}, 32'd3);
      end else if (cnt < FRAME_LEN) begin
         checkOutput("sda", {31'd0, busIf.o_sda_out}, {31'd0, mFrame[cnt]});
         checkOutput("phase", {30'd0, busIf.o_phase}, {30'd0, expPhase(cnt)});
         cap[cnt] = busIf.o_sda_out;
      end
      sampledEn = busIf.o_bitcnt_en;
      lastBusy  = busIf.o_busy;
      lastDone  = busIf.o_done;
      if (busIf.o_done) dutDones++;
      @(posedge clk);
      if (!rstN) begin
         mActive = 1'b0;
         mFinish = 1'b0;
      end else if (mFinish) begin
         mFinish = 1'b0;
      end else if (mActive) begin
         if (ab) begin
            mActive = 1'b0;
         end else if (cnt >= FRAME_LEN) begin
            mActive = 1'b0;
            mFinish = 1'b1;
            mDones++;
         end
      end else if (st && !ab) begin
         mActive = 1'b1;
         mFrame  = buildFrame(p, w);
      end
      if (!sampledEn) cnt = '0;
      else if (jumpTo >= 0) begin
         cnt    = 5'(jumpTo);
         jumpTo = -1;
      end else if ($urandom_range(3) != 0) cnt = cnt + 5'd1;
      #1;
      busIf.i_bit_count = cnt;
   endtask

   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 16'h0000, 2'b00);
   endtask

   task automatic runToCount(input int target, input int budget);
      int n = 0;
      while (!(mActive && cnt == 5'(target)) && n < budget) begin
         idleCycle();
         n++;
      end
      if (n >= budget) checkOutput("reachCount", 32'd0, 32'd1);
   endtask

   task automatic runToDone(input int budget);
      int n = 0;
      do begin
         idleCycle();
         n++;
      end while (!lastDone && n < budget);
      if (!lastDone) checkOutput("doneTimeout", 32'd0, 32'd1);
   endtask

   task automatic runToIdle(input int budget);
      int n = 0;
      do begin
         idleCycle();
         n++;
      end while (lastBusy && n < budget);
      if (lastBusy) checkOutput("idleTimeout", 32'd1, 32'd0);
   endtask

   initial begin
      logic [0:19] expA5C3;
      logic [0:19] exp0000;
      int          donesBefore;
      expA5C3 = 20'b10_1010_0101_1100_0011_01;
      exp0000 = 20'b11_0000_0000_0000_0000_01;

      busIf.i_start = 1'b0;
      busIf.i_abort = 1'b0;
      busIf.i_word = '0;
      busIf.i_preamble = '0;
      busIf.i_bit_count = '0;
      @(posedge clk);
      #1;
      repeat (3) idleCycle();
      rstN = 1'b1;
      idleCycle();

      $display("[TB] word A5C3 preamble 10");
      cap = '0;
      applyStimulus(1'b1, 1'b0, 16'hA5C3, 2'b10);
      checkOutput("firstCount", {27'd0, cnt}, 32'd0);
      runToIdle(200);
      checkOutput("seqA5C3", {12'd0, cap}, {12'd0, expA5C3});
      checkOutput("doneCount", dutDones, 1);

      $display("[TB] word 0000 preamble 11");
      cap = '0;
      applyStimulus(1'b1, 1'b0, 16'h0000, 2'b11);
      runToIdle(200);
      checkOutput("seq0000", {12'd0, cap}, {12'd0, exp0000});
      checkOutput("doneCount", dutDones, mDones);

      $display("[TB] start ignored during word");
      donesBefore = dutDones;
      cap = '0;
      applyStimulus(1'b1, 1'b0, 16'h0000, 2'b11);
      runToCount(7, 100);
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 2'b00);
      runToIdle(200);
      checkOutput("seqUnchanged", {12'd0, cap}, {12'd0, exp0000});
      checkOutput("oneDone", dutDones - donesBefore, 1);

      $display("[TB] abort at count 10 then restart");
      donesBefore = dutDones;
      applyStimulus(1'b1, 1'b0, 16'h1234, 2'b01);
      runToCount(10, 100);
      applyStimulus(1'b0, 1'b1, 16'h0000, 2'b00);
      applyStimulus(1'b1, 1'b0, 16'hBEEF, 2'b10);
      checkOutput("restartCount", {27'd0, cnt}, 32'd0);
      runToIdle(200);
      checkOutput("abortDones", dutDones - donesBefore, 1);

      $display("[TB] abort together with count 20");
      donesBefore = dutDones;
      applyStimulus(1'b1, 1'b0, 16'h8001, 2'b11);
      runToCount(FRAME_LEN, 100);
      applyStimulus(1'b0, 1'b1, 16'h0000, 2'b00);
      idleCycle();
      checkOutput("noDone", dutDones - donesBefore, 0);

      $display("[TB] back-to-back words");
      donesBefore = dutDones;
      applyStimulus(1'b1, 1'b0, 16'h0F0F, 2'b10);
      runToDone(200);
      applyStimulus(1'b1, 1'b0, 16'hF00D, 2'b01);
      checkOutput("b2bCount1", {27'd0, cnt}, 32'd0);
      runToDone(200);
      cap = '0;
      applyStimulus(1'b1, 1'b0, 16'hA5C3, 2'b10);
      checkOutput("b2bCount2", {27'd0, cnt}, 32'd0);
      runToIdle(200);
      checkOutput("b2bSeq", {12'd0, cap}, {12'd0, expA5C3});
      checkOutput("b2bDones", dutDones - donesBefore, 3);

      $display("[TB] count overshoot treated as completion");
      donesBefore = dutDones;
      applyStimulus(1'b1, 1'b0, 16'h5A5A, 2'b00);
      runToCount(12, 100);
      jumpTo = 25;
      idleCycle();
      runToIdle(200);
      checkOutput("overshootDone", dutDones - donesBefore, 1);

      $display("[TB] asynchronous reset mid-word");
      applyStimulus(1'b1, 1'b0, 16'hC3A5, 2'b01);
      runToCount(5, 100);
      #2;
      rstN = 1'b0;
      #1;
      checkOutput("rstEn", {31'd0, busIf.o_bitcnt_en}, 32'd0);
      checkOutput("rstSda", {31'd0, busIf.o_sda_out}, 32'd1);
      checkOutput("rstBusy", {31'd0, busIf.o_busy}, 32'd0);
      checkOutput("rstPhase", {30'd0, busIf.o_phase}, 32'd3);
      checkOutput("rstDone", {31'd0, busIf.o_done}, 32'd0);
      mActive = 1'b0;
      mFinish = 1'b0;
      @(posedge clk);
      #1;
      repeat (2) idleCycle();
      rstN = 1'b1;
      idleCycle();

      $display("[TB] random soak");
      for (int i = 0; i < 1500; i++) begin
         applyStimulus($urandom_range(7) == 0, $urandom_range(49) == 0,
                       16'($urandom), 2'($urandom));
      end
      runToIdle(200);
      checkOutput("totalDones", dutDones, mDones);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddr_word_tx_ctrl.md
Name: ddr_word_tx_ctrl

Overview:
Sequences one I3C HDR-DDR word onto SDA: 2 preamble bits, 16 data bits MSB first, then 2 parity bits, for 20 bits total. It owns the enable of the SCL-edge bit counter and reads that counter's 5-bit count back to pick the bit currently driven. It sits between the HDR-DDR engine (start/word/preamble/abort) and the SDA output mux. It also reports phase and completion upstream.

Parameters:
CNT_W, 5, width of the bit-count input from the bit counter.
FRAME_LEN, 20, number of bits per word; the counter value equal to FRAME_LEN marks completion.

Ports:
i_sys_clk  input  1  system clock, all logic on its rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  one-cycle request to send a word; sampled only in IDLE
i_word  input  16  data word; sampled with i_start
i_preamble  input  2  preamble bits; sampled with i_start; bit 1 is sent first
i_abort  input  1  terminates the current word
i_bit_count  input  CNT_W  count from the bit counter
o_bitcnt_en  output  1  enable to the bit counter; low clears the counter
o_sda_out  output  1  serial bit toward the SDA mux
o_busy  output  1  high in RUN and DONE
o_done  output  1  one-cycle pulse when a word completes normally
o_phase  output  2  0=preamble, 1=data, 2=parity, 3=idle/done

Behaviour:
- Clock and reset: single clock i_sys_clk; asynchronous active-low reset i_rst_n.
- Reset values: state=IDLE, frame register=0, o_bitcnt_en=0, o_sda_out=1, o_busy=0, o_done=0, o_phase=3.
- Frame register (20 bits), latched on accepted start: {i_preamble, i_word, PA1, PA0}.
  - PA1 = XOR of i_word bits 15,13,11,9,7,5,3,1.
  - PA0 = XOR of i_word bits 14,12,10,8,6,4,2,0, then XOR 1.
- Frame bit index k is transmitted when i_bit_count==k, for k=0..19. Bit 0 of the frame is its MSB (frame[19]).
- FSM states: IDLE, RUN, DONE.
  - IDLE: i_start=1 latches the frame and moves to RUN. o_bitcnt_en goes high the cycle after i_start (registered). SCL edges in the i_start cycle are not counted.
  - RUN: o_sda_out = frame[19 - i_bit_count], combinational from the frame register and i_bit_count.
    - o_phase: 0 for count 0..1, 1 for count 2..17, 2 for count 18..19.
    - When i_bit_count==FRAME_LEN: move to DONE, drive o_bitcnt_en=0 next cycle, pulse o_done for exactly one cycle.
  - DONE: o_bitcnt_en=0, o_sda_out=1, o_phase=3, o_busy=1. Unconditionally returns to IDLE next cycle. This guarantees one cleared-counter cycle between words.
  - i_abort=1 in RUN or DONE: go to IDLE next cycle, o_bitcnt_en=0, no o_done, frame register retained. Abort wins over completion if both occur in the same cycle.
- i_start outside IDLE is ignored, not queued. i_start and i_abort together in IDLE: abort wins, start is dropped.
- i_bit_count > FRAME_LEN in RUN cannot occur by protocol. If seen, treat it as completion.
- Reset mid-word: all outputs return to reset values asynchronously. The counter clears because o_bitcnt_en drops.
- Back-to-back: the minimum spacing from o_done to the next accepted i_start is 2 cycles (DONE, then IDLE).
- Latency:
  - i_start to o_bitcnt_en: 1 cycle.
  - Count reaching 20 to o_done: 1 cycle.
  - o_sda_out follows i_bit_count with 0 cycles of latency.

Test Plan:
- Reset: assert i_rst_n=0 mid-RUN -> o_bitcnt_en=0, o_sda_out=1, o_busy=0, o_phase=3 immediately.
- Word 0xA5C3, preamble 2'b10, counter model stepping 0..20 -> SDA sequence 1,0, 1010010111000011, PA1=0, PA0=1. o_phase goes 0,0, then 1 ×16, then 2,2. o_done pulses once, then o_busy drops 2 cycles after the count reaches 20.
- Word 0x0000, preamble 2'b11 -> parity bits 0,1; total 20 bits; o_done=1 for 1 cycle.
- i_start asserted again during RUN at count 7 -> ignored. The current word completes unchanged, and only one o_done is produced.
- i_abort at count 10 -> o_bitcnt_en=0 next cycle, state IDLE, no o_done. A new i_start 1 cycle later is accepted.
- Simultaneous i_abort and count==20 -> no o_done, IDLE next cycle. Back-to-back starts issued 2 cycles after o_done -> both words are sent correctly, each starting from count 0.
